// File: rtl/count_display_driver_pkg.sv
// count_disp_pkg: shared types and constants for the count display driver.
//   conv_state_t : converter FSM states (IDLE, SHIFT, DONE)
//   SEG_DIGIT    : active-low {g,f,e,d,c,b,a} codes for digits 0..9
//   SEG_OFF      : all segments dark
//   AN_OFF       : all anodes dark
//   BCD_W        : width of the 3-digit BCD result
//   SHIFTS       : shifts per conversion (one per input bit)
//   seg_encode() : BCD nibble -> segment code; non-BCD nibbles go dark
package count_disp_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

   localparam int BCD_W  = 12;
   localparam int SHIFTS = 8;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] r;
      r = SEG_OFF;
      for (int i = 0; i < 10; i++)
         if (d == 4'(i)) r = SEG_DIGIT[i];
      return r;
   endfunction

endpackage

// File: rtl/count_display_driver_bin2bcd.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) binary to BCD converter.
//   clk, rst : clock, synchronous active-high reset
//   start    : sampled in IDLE; captures bin and begins a conversion
//   bin      : 8-bit unsigned input
//   busy     : high whenever the FSM is not in IDLE
//   bcd      : {hund,tens,ones} of the last completed conversion
//   done     : one-cycle pulse, coincident with the first cycle bcd shows a new result
module bin2bcd_seq
   import count_disp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       bin,
   output logic             busy,
   output logic [BCD_W-1:0] bcd,
   output logic             done
);

   conv_state_t      state, state_nxt;
   logic [7:0]       src;
   logic [BCD_W-1:0] scratch;
   logic [3:0]       iter;
   logic [BCD_W-1:0] adj;
   logic [BCD_W+7:0] shifted;

   // Add 3 to any nibble >= 5 so it carries correctly into the next digit
   // after the doubling shift. 255 -> 0x255, so 12 bits never overflow.
   always_comb begin
      adj = scratch;
      for (int n = 0; n < BCD_W / 4; n++)
         if (scratch[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = scratch[n*4 +: 4] + 4'd3;
      shifted = {adj[BCD_W-2:0], src, 1'b0};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (iter == 4'(SHIFTS - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         src     <= '0;
         scratch <= '0;
         iter    <= '0;
         bcd     <= '0;
         done    <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               src     <= bin;
               scratch <= '0;
               iter    <= '0;
            end
            SHIFT: begin
               {scratch, src} <= shifted;
               iter           <= iter + 4'd1;
            end
            DONE: begin
               bcd  <= scratch;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: converts the 8-bit counter value to BCD and scans it
// onto a 4-digit common-anode 7-segment display.
//   clk, rst  : clock, synchronous active-high reset
//   count     : unsigned value from the counter
//   seg       : {g,f,e,d,c,b,a}, active low
//   an        : digit anodes, active low; an[0]=ones, an[1]=tens, an[2]=hundreds
//   bcd       : {hund,tens,ones}, last completed conversion
//   conv_done : one-cycle pulse when bcd updates
// Parameters: CLK_DIV clocks per scan slot (>= 2); BLANK_LZ blanks leading zeros.
module count_display_driver
   import count_disp_pkg::*;
#(
   parameter int CLK_DIV  = 100000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       count,
   output logic [6:0]       seg,
   output logic [3:0]       an,
   output logic [BCD_W-1:0] bcd,
   output logic             conv_done
);

   localparam int            PW   = $clog2(CLK_DIV);
   localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

   logic [7:0]    shadow;
   logic          shadow_valid;
   logic          busy, start;
   logic [PW-1:0] presc;
   logic          tick;
   logic [1:0]    idx;
   logic [3:0]    digit;
   logic          lit;
   logic [6:0]    seg_nxt;
   logic [3:0]    an_nxt;

   // Only look for a new value while the converter is idle, so a value that
   // changes mid-conversion is picked up afterwards and bcd never tears.
   assign start = !busy && (!shadow_valid || count != shadow);

   // The shadow is only compared while idle, and the converter is never idle
   // between acceptance and completion, so marking it valid on acceptance is
   // indistinguishable from marking it on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow       <= '0;
         shadow_valid <= 1'b0;
      end else if (start) begin
         shadow       <= count;
         shadow_valid <= 1'b1;
      end
   end

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (count),
      .busy  (busy),
      .bcd   (bcd),
      .done  (conv_done)
   );

   assign tick = (presc == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) idx <= idx + 2'd1;
      end
   end

   always_comb begin
      digit   = 4'd0;
      lit     = 1'b0;
      an_nxt  = AN_OFF;
      seg_nxt = SEG_OFF;
      case (idx)
         2'd0: begin
            digit = bcd[3:0];
            lit   = 1'b1;
         end
         2'd1: begin
            digit = bcd[7:4];
            lit   = !(BLANK_LZ && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0);
         end
         2'd2: begin
            digit = bcd[11:8];
            lit   = !(BLANK_LZ && bcd[11:8] == 4'd0);
         end
         default: lit = 1'b0;
      endcase
      if (lit) begin
         an_nxt  = ~(4'b0001 << idx);
         seg_nxt = seg_encode(digit);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= seg_nxt;
         an  <= an_nxt;
      end
   end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench: two instances (BLANK_LZ=1 and BLANK_LZ=0) share clk/rst/count.
module tb_count_display_driver;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  count = 8'd0;
   logic [6:0]  seg1, seg0;
   logic [3:0]  an1, an0;
   logic [11:0] bcd1, bcd0;
   logic        done1, done0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   localparam logic [6:0] SEG [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
   };

   always #5 clk = ~clk;

   count_display_driver #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .count(count),
      .seg(seg1), .an(an1), .bcd(bcd1), .conv_done(done1)
   );

   count_display_driver #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b0)) dut0 (
      .clk(clk), .rst(rst), .count(count),
      .seg(seg0), .an(an0), .bcd(bcd0), .conv_done(done0)
   );

   // Expected {an,seg} for scan slot ix showing BCD value b.
   function automatic logic [10:0] exp_disp(input int ix, input logic [11:0] b, input bit blz);
      logic [3:0] a;
      logic [6:0] s;
      a = 4'hF;
      s = 7'h7F;
      case (ix)
         0: begin a = 4'hE; s = SEG[b[3:0]]; end
         1: if (!(blz && b[11:4] == 8'h00)) begin a = 4'hD; s = SEG[b[7:4]]; end
         2: if (!(blz && b[11:8] == 4'h0)) begin a = 4'hB; s = SEG[b[11:8]]; end
         default: ;
      endcase
      return {a, s};
   endfunction

   // One clock; sample 1 time unit after the edge. cyc counts edges since reset.
   task automatic step();
      @(posedge clk);
      #1;
      if (rst) cyc = 0;
      else cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      count = 8'd0;
      repeat (3) step();
      total++; if (seg1 !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg1); end
      total++; if (an1 !== 4'hF) begin bad++; $display("FAIL reset_an got=%h exp=f", an1); end
      total++; if (bcd1 !== 12'h000) begin bad++; $display("FAIL reset_bcd got=%h exp=000", bcd1); end
      total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done1); end
      total++; if ({an0, seg0} !== 11'h7FF) begin bad++; $display("FAIL reset_disp0 got=%h exp=7ff", {an0, seg0}); end
   endtask

   task automatic test_first_conv();
      int first, n;
      logic [10:0] e1, e0;
      first = -1;
      n = 0;
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (done1) begin
            n++;
            if (first < 0) first = k;
         end
      end
      total++; if (first != 10) begin bad++; $display("FAIL first_done_lat got=%0d exp=10", first); end
      total++; if (n != 1) begin bad++; $display("FAIL first_done_count got=%0d exp=1", n); end
      total++; if (bcd1 !== 12'h000) begin bad++; $display("FAIL first_bcd got=%h exp=000", bcd1); end
      for (int k = 0; k < 16; k++) begin
         step();
         e1 = exp_disp(((cyc - 1) / CLK_DIV) % 4, 12'h000, 1'b1);
         e0 = exp_disp(((cyc - 1) / CLK_DIV) % 4, 12'h000, 1'b0);
         total++; if ({an1, seg1} !== e1) begin bad++; $display("FAIL scan0_lz got=%h exp=%h", {an1, seg1}, e1); end
         total++; if ({an0, seg0} !== e0) begin bad++; $display("FAIL scan0_nolz got=%h exp=%h", {an0, seg0}, e0); end
      end
   endtask

   task automatic test_255();
      logic [10:0] e1;
      count = 8'd255;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 9) begin
            total++; if (bcd1 !== 12'h000) begin bad++; $display("FAIL c255_early got=%h exp=000", bcd1); end
         end
      end
      total++; if (bcd1 !== 12'h255) begin bad++; $display("FAIL c255_bcd got=%h exp=255", bcd1); end
      total++; if (done1 !== 1'b1) begin bad++; $display("FAIL c255_done got=%b exp=1", done1); end
      total++; if (bcd0 !== 12'h255) begin bad++; $display("FAIL c255_bcd0 got=%h exp=255", bcd0); end
      repeat (2) step();
      for (int k = 0; k < 16; k++) begin
         step();
         e1 = exp_disp(((cyc - 1) / CLK_DIV) % 4, 12'h255, 1'b1);
         total++; if ({an1, seg1} !== e1) begin bad++; $display("FAIL scan255 got=%h exp=%h", {an1, seg1}, e1); end
         total++; if ({an0, seg0} !== e1) begin bad++; $display("FAIL scan255_nolz got=%h exp=%h", {an0, seg0}, e1); end
      end
   endtask

   task automatic test_blank_7();
      logic [10:0] e1, e0;
      count = 8'd7;
      repeat (12) step();
      total++; if (bcd1 !== 12'h007) begin bad++; $display("FAIL c7_bcd got=%h exp=007", bcd1); end
      for (int k = 0; k < 16; k++) begin
         step();
         e1 = exp_disp(((cyc - 1) / CLK_DIV) % 4, 12'h007, 1'b1);
         e0 = exp_disp(((cyc - 1) / CLK_DIV) % 4, 12'h007, 1'b0);
         total++; if ({an1, seg1} !== e1) begin bad++; $display("FAIL scan7_lz got=%h exp=%h", {an1, seg1}, e1); end
         total++; if ({an0, seg0} !== e0) begin bad++; $display("FAIL scan7_nolz got=%h exp=%h", {an0, seg0}, e0); end
      end
   endtask

   task automatic test_inner_zero_105();
      logic [10:0] e1;
      count = 8'd105;
      repeat (12) step();
      total++; if (bcd1 !== 12'h105) begin bad++; $display("FAIL c105_bcd got=%h exp=105", bcd1); end
      for (int k = 0; k < 16; k++) begin
         step();
         e1 = exp_disp(((cyc - 1) / CLK_DIV) % 4, 12'h105, 1'b1);
         total++; if ({an1, seg1} !== e1) begin bad++; $display("FAIL scan105 got=%h exp=%h", {an1, seg1}, e1); end
      end
   endtask

   task automatic test_back_to_back();
      int n, k1, k2, torn;
      logic [11:0] b1, b2;
      n = 0; k1 = -1; k2 = -1; torn = 0;
      b1 = 12'hFFF; b2 = 12'hFFF;
      count = 8'd100;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 2) count = 8'd101;
         if (bcd1 !== 12'h105 && bcd1 !== 12'h100 && bcd1 !== 12'h101) torn++;
         if (done1) begin
            n++;
            if (n == 1) begin k1 = k; b1 = bcd1; end
            if (n == 2) begin k2 = k; b2 = bcd1; end
         end
      end
      total++; if (k1 != 10 || b1 !== 12'h100) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=10/100", k1, b1); end
      total++; if (k2 != 20 || b2 !== 12'h101) begin bad++; $display("FAIL b2b_second got=%0d/%h exp=20/101", k2, b2); end
      total++; if (n != 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", n); end
      total++; if (torn != 0) begin bad++; $display("FAIL b2b_torn got=%0d exp=0", torn); end
   endtask

   task automatic test_reset_mid();
      int n, first;
      logic [10:0] e1;
      n = 0; first = -1;
      count = 8'd200;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (done1) n++;
      end
      rst = 1'b1;
      step();
      total++; if (bcd1 !== 12'h000) begin bad++; $display("FAIL midrst_bcd got=%h exp=000", bcd1); end
      total++; if (an1 !== 4'hF) begin bad++; $display("FAIL midrst_an got=%h exp=f", an1); end
      total++; if (seg1 !== 7'h7F) begin bad++; $display("FAIL midrst_seg got=%h exp=7f", seg1); end
      total++; if (done1 !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", done1); end
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (done1) begin
            n++;
            if (first < 0) first = k;
         end
      end
      total++; if (first != 10) begin bad++; $display("FAIL midrst_lat got=%0d exp=10", first); end
      total++; if (n != 1) begin bad++; $display("FAIL midrst_count got=%0d exp=1", n); end
      total++; if (bcd1 !== 12'h200) begin bad++; $display("FAIL midrst_result got=%h exp=200", bcd1); end
      repeat (2) step();
      for (int k = 0; k < 16; k++) begin
         step();
         e1 = exp_disp(((cyc - 1) / CLK_DIV) % 4, 12'h200, 1'b1);
         total++; if ({an1, seg1} !== e1) begin bad++; $display("FAIL scan200 got=%h exp=%h", {an1, seg1}, e1); end
      end
   endtask

   initial begin
      test_reset();
      test_first_conv();
      test_255();
      test_blank_7();
      test_inner_zero_105();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
